// File: rtl/reg_debug_master.sv
// reg_debug_master: debug-side initiator that fills or dumps the whole register file
module reg_debug_master #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [WORD_BITWIDTH-1:0]    cmd_data,
    output logic [REG_NUM_BITWIDTH-1:0] regToRead1,
    input  logic [WORD_BITWIDTH-1:0]    read_data1,
    output logic [REG_NUM_BITWIDTH-1:0] regToWrite,
    output logic [WORD_BITWIDTH-1:0]    write_data,
    output logic                        doRegWrite,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic [WORD_BITWIDTH-1:0]    dump_data,
    output logic [REG_NUM_BITWIDTH-1:0] dump_index,
    output logic                        busy,
    output logic                        done
);
    typedef enum logic [2:0] {IDLE, FILL, DUMP_RD, DUMP_OUT, DONE} state_t;
    localparam logic [REG_NUM_BITWIDTH-1:0] LAST = '1;
    localparam logic [REG_NUM_BITWIDTH-1:0] ONE  = 1;
    state_t                      r_state;
    logic [REG_NUM_BITWIDTH-1:0] r_idx;
    logic [WORD_BITWIDTH-1:0]    r_word;
    logic [WORD_BITWIDTH-1:0]    r_dump;
    logic                        w_fill;
    logic                        w_out;
    // command sequencer: walks every index once, last index caught explicitly so idx never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_word  <= '0;
            r_dump  <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_idx   <= '0;
                    r_word  <= cmd_data;
                    r_state <= cmd_op ? FILL : DUMP_RD;
                end
                FILL: begin
                    if (r_idx == LAST) r_state <= DONE;
                    else r_idx <= r_idx + ONE;
                end
                DUMP_RD: begin
                    r_dump  <= read_data1;
                    r_state <= DUMP_OUT;
                end
                DUMP_OUT: if (dump_ready) begin
                    if (r_idx == LAST) r_state <= DONE;
                    else begin
                        r_idx   <= r_idx + ONE;
                        r_state <= DUMP_RD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign w_fill     = r_state == FILL;
    assign w_out      = r_state == DUMP_OUT;
    assign cmd_ready  = r_state == IDLE;
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    assign doRegWrite = w_fill;
    assign regToWrite = w_fill ? r_idx : '0;
    assign write_data = w_fill ? r_word : '0;
    assign regToRead1 = r_state == DUMP_RD ? r_idx : '0;
    assign dump_valid = w_out;
    assign dump_data  = w_out ? r_dump : '0;
    assign dump_index = w_out ? r_idx : '0;
endmodule

// File: tb/tb_reg_debug_master.sv
// tb_reg_debug_master: directed tests for fill, dump, stalls, ignored commands and mid-command reset
module tb_reg_debug_master;
    localparam int RB = 5;
    localparam int WB = 32;
    localparam int N  = 32;
    logic          clk = 0;
    logic          rst = 0;
    logic          cmd_valid = 0;
    logic          cmd_ready;
    logic          cmd_op = 0;
    logic [WB-1:0] cmd_data = '0;
    logic [RB-1:0] regToRead1;
    logic [WB-1:0] read_data1;
    logic [RB-1:0] regToWrite;
    logic [WB-1:0] write_data;
    logic          doRegWrite;
    logic          dump_valid;
    logic          dump_ready = 0;
    logic [WB-1:0] dump_data;
    logic [RB-1:0] dump_index;
    logic          busy;
    logic          done;
    logic [WB-1:0] rf [N];
    logic [1:0]    pre = 0;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    reg_debug_master #(.REG_NUM_BITWIDTH(RB), .WORD_BITWIDTH(WB)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .regToRead1(regToRead1), .read_data1(read_data1),
        .regToWrite(regToWrite), .write_data(write_data), .doRegWrite(doRegWrite),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_index(dump_index), .busy(busy), .done(done)
    );

    // register file model: 1 = preload i*0x1111, 2 = clear, else normal write port
    always @(posedge clk) begin
        if (pre == 2'd1) for (int i = 0; i < N; i++) rf[i] <= WB'(i * 32'h1111);
        else if (pre == 2'd2) for (int i = 0; i < N; i++) rf[i] <= '0;
        else if (doRegWrite) rf[regToWrite] <= write_data;
    end
    assign read_data1 = rf[regToRead1];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] m);
        pre = m;
        step;
        pre = 0;
    endtask

    task automatic issue(input logic op, input logic [WB-1:0] d);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1;
        step;
        cmd_valid = 0;
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b, want 1 0 0", cmd_ready, busy, done);
        end
        step;
        step;
        tests++;
        if (doRegWrite !== 1'b0 || regToWrite !== '0 || write_data !== '0 || regToRead1 !== '0) begin
            fails++;
            $display("FAIL reset_port: got we=%b wi=%0d wd=%h ri=%0d, want 0 0 0 0", doRegWrite, regToWrite, write_data, regToRead1);
        end
        tests++;
        if (dump_valid !== 1'b0 || dump_data !== '0 || dump_index !== '0) begin
            fails++;
            $display("FAIL reset_dump: got v=%b d=%h i=%0d, want 0 0 0", dump_valid, dump_data, dump_index);
        end
        rst = 1;
        step;
    endtask

    task automatic test_fill;
        int bad;
        load(2);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_ready: got %b, want 1", cmd_ready);
        end
        issue(1'b1, 32'hA5A5_0001);
        for (int k = 0; k < N; k++) begin
            tests++;
            if (doRegWrite !== 1'b1 || regToWrite !== RB'(k) || write_data !== 32'hA5A5_0001 || done !== 1'b0) begin
                fails++;
                $display("FAIL fill_cycle%0d: got we=%b idx=%0d wd=%h done=%b, want 1 %0d a5a50001 0", k, doRegWrite, regToWrite, write_data, done, k);
            end
            step;
        end
        tests++;
        if (done !== 1'b1 || doRegWrite !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL fill_done: got done=%b we=%b busy=%b, want 1 0 1", done, doRegWrite, busy);
        end
        step;
        tests++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL fill_idle: got ready=%b done=%b busy=%b, want 1 0 0", cmd_ready, done, busy);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (rf[i] !== 32'hA5A5_0001) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL fill_contents: got %0d wrong registers, want 0", bad);
        end
    endtask

    task automatic test_dump;
        load(1);
        dump_ready = 1;
        issue(1'b0, '0);
        for (int k = 0; k < N; k++) begin
            tests++;
            if (dump_valid !== 1'b0 || regToRead1 !== RB'(k) || busy !== 1'b1) begin
                fails++;
                $display("FAIL dump_rd%0d: got v=%b ri=%0d busy=%b, want 0 %0d 1", k, dump_valid, regToRead1, busy, k);
            end
            step;
            tests++;
            if (dump_valid !== 1'b1 || dump_index !== RB'(k) || dump_data !== WB'(k * 32'h1111) || doRegWrite !== 1'b0) begin
                fails++;
                $display("FAIL dump_word%0d: got v=%b i=%0d d=%h we=%b, want 1 %0d %h 0", k, dump_valid, dump_index, dump_data, doRegWrite, k, WB'(k * 32'h1111));
            end
            step;
        end
        tests++;
        if (done !== 1'b1 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL dump_done: got done=%b v=%b, want 1 0", done, dump_valid);
        end
        step;
        tests++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL dump_idle: got ready=%b done=%b, want 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_stall;
        int exp_k;
        int ndone;
        logic pv;
        logic pr;
        logic [RB-1:0] pi;
        logic [WB-1:0] pd;
        exp_k = 0;
        ndone = 0;
        pv = 0;
        pr = 0;
        pi = '0;
        pd = '0;
        load(1);
        issue(1'b0, '0);
        for (int c = 0; c < 400 && ndone == 0; c++) begin
            dump_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                tests++;
                if (dump_valid !== 1'b1 || dump_index !== pi || dump_data !== pd) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b i=%0d d=%h, want 1 %0d %h", dump_valid, dump_index, dump_data, pi, pd);
                end
            end
            if (dump_valid === 1'b1) begin
                tests++;
                if (dump_index !== RB'(exp_k) || dump_data !== WB'(exp_k * 32'h1111)) begin
                    fails++;
                    $display("FAIL stall_order: got i=%0d d=%h, want %0d %h", dump_index, dump_data, exp_k, WB'(exp_k * 32'h1111));
                end
                if (dump_ready) exp_k++;
            end
            if (done === 1'b1) ndone++;
            pv = dump_valid;
            pr = dump_ready;
            pi = dump_index;
            pd = dump_data;
            step;
        end
        tests++;
        if (ndone != 1 || exp_k != N) begin
            fails++;
            $display("FAIL stall_count: got done=%0d words=%0d, want 1 %0d", ndone, exp_k, N);
        end
        dump_ready = 1;
    endtask

    task automatic test_ignore;
        int words;
        int bad;
        logic seen;
        words = 0;
        seen = 0;
        load(1);
        dump_ready = 1;
        issue(1'b0, '0);
        for (int c = 0; c < 100 && !seen; c++) begin
            if (c == 5) begin
                cmd_op = 1;
                cmd_data = 32'hFFFF_FFFF;
                cmd_valid = 1;
            end
            if (c == 8) cmd_valid = 0;
            tests++;
            if (doRegWrite !== 1'b0 || cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL ignore_busy%0d: got we=%b ready=%b, want 0 0", c, doRegWrite, cmd_ready);
            end
            if (dump_valid === 1'b1) begin
                tests++;
                if (dump_index !== RB'(words) || dump_data !== WB'(words * 32'h1111)) begin
                    fails++;
                    $display("FAIL ignore_word: got i=%0d d=%h, want %0d %h", dump_index, dump_data, words, WB'(words * 32'h1111));
                end
                words++;
            end
            if (done === 1'b1) seen = 1;
            step;
        end
        tests++;
        if (!seen || words != N || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ignore_end: got done=%b words=%0d ready=%b, want 1 %0d 1", seen, words, cmd_ready, N);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (rf[i] !== WB'(i * 32'h1111)) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ignore_contents: got %0d changed registers, want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        load(2);
        issue(1'b1, 32'h1234_5678);
        for (int k = 0; k < 9; k++) step;
        tests++;
        if (doRegWrite !== 1'b1 || regToWrite !== RB'(9)) begin
            fails++;
            $display("FAIL rstmid_pre: got we=%b idx=%0d, want 1 9", doRegWrite, regToWrite);
        end
        #2;
        rst = 0;
        #1;
        tests++;
        if (doRegWrite !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_async: got we=%b busy=%b ready=%b, want 0 0 1", doRegWrite, busy, cmd_ready);
        end
        step;
        step;
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || doRegWrite !== 1'b0 || regToWrite !== '0 ||
                write_data !== '0 || regToRead1 !== '0 || dump_valid !== 1'b0 || dump_data !== '0 || dump_index !== '0) begin
                fails++;
                $display("FAIL rstmid_idle%0d: got ready=%b busy=%b done=%b we=%b wi=%0d wd=%h ri=%0d v=%b d=%h i=%0d, want 1 0 0 0 0 0 0 0 0 0",
                         c, cmd_ready, busy, done, doRegWrite, regToWrite, write_data, regToRead1, dump_valid, dump_data, dump_index);
            end
            step;
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (rf[i] !== (i < 9 ? 32'h1234_5678 : 32'h0)) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rstmid_contents: got %0d wrong registers, want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        int words;
        logic seen;
        w = -1;
        words = 0;
        seen = 0;
        load(1);
        dump_ready = 1;
        issue(1'b1, 32'h0);
        for (int c = 0; c < 60; c++) begin
            if (cmd_ready === 1'b1) begin
                w = c;
                break;
            end
            step;
        end
        tests++;
        if (w != N + 1) begin
            fails++;
            $display("FAIL b2b_ready: got first ready at %0d, want %0d", w, N + 1);
        end
        issue(1'b0, '0);
        for (int c = 0; c < 200 && !seen; c++) begin
            if (dump_valid === 1'b1) begin
                tests++;
                if (dump_index !== RB'(words) || dump_data !== '0) begin
                    fails++;
                    $display("FAIL b2b_word: got i=%0d d=%h, want %0d 0", dump_index, dump_data, words);
                end
                words++;
            end
            if (done === 1'b1) seen = 1;
            step;
        end
        tests++;
        if (!seen || words != N) begin
            fails++;
            $display("FAIL b2b_count: got done=%b words=%0d, want 1 %0d", seen, words, N);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_dump;
        test_stall;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_debug_master.md
# reg_debug_master

Debug-side initiator for the 32-entry general register file: it drives the file's write port and one read port to either fill every register with a given word or dump every register out on a valid/ready stream. It sits between the debug/boot controller and the register file, and owns the file's port signals only while the core is halted. One command runs at a time; each command walks all register indices in order.

## Interface
- REG_NUM_BITWIDTH, 5, register index width; number of registers N = 2**REG_NUM_BITWIDTH
- WORD_BITWIDTH, 32, register data width
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; command accepted on cycle with cmd_valid && cmd_ready
- cmd_op  input  1  0 = DUMP, 1 = FILL; sampled at acceptance
- cmd_data  input  WORD_BITWIDTH  fill word; sampled at acceptance
- regToRead1  output  REG_NUM_BITWIDTH  read index to register file
- read_data1  input  WORD_BITWIDTH  combinational read data from register file
- regToWrite  output  REG_NUM_BITWIDTH  write index to register file
- write_data  output  WORD_BITWIDTH  write data to register file
- doRegWrite  output  1  write enable to register file
- dump_valid  output  1  dump word available
- dump_ready  input  1  consumer accepts dump word
- dump_data  output  WORD_BITWIDTH  dumped register value
- dump_index  output  REG_NUM_BITWIDTH  index of dump_data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at command completion

## Operation
- States: IDLE, FILL, DUMP_RD, DUMP_OUT, DONE. Index counter idx (REG_NUM_BITWIDTH bits), fill word register, dump data register.
- IDLE: cmd_ready=1. On acceptance: idx<=0, latch cmd_data; cmd_op=1 -> FILL, cmd_op=0 -> DUMP_RD.
- FILL: doRegWrite=1, regToWrite=idx, write_data=latched word. Each cycle idx++; at idx==N-1 -> DONE. Index 0 is written like any other (file has no hardwired zero).
- DUMP_RD: regToRead1=idx; at edge capture read_data1 into dump data register -> DUMP_OUT.
- DUMP_OUT: dump_valid=1, dump_data=captured value, dump_index=idx, both stable until handshake. On dump_valid && dump_ready: idx==N-1 -> DONE, else idx++ and -> DUMP_RD.
- DONE: done=1 for exactly one cycle -> IDLE.
- Outside its active state: doRegWrite=0, regToWrite=0, write_data=0, regToRead1=0, dump_valid=0.
- cmd_valid while busy: ignored, not queued. idx never wraps mid-command; the last index is detected explicitly.

## Timing
- Reset (asynchronous, immediate): state IDLE, idx=0, cmd_ready=1, busy=0, done=0, doRegWrite=0, regToWrite=0, write_data=0, regToRead1=0, dump_valid=0, dump_data=0, dump_index=0.
- Reset mid-command aborts: doRegWrite drops asynchronously, and no further writes or dump words follow.
- FILL accepted at edge T: doRegWrite high in cycles T+1..T+N with regToWrite 0..N-1; done in cycle T+N+1; cmd_ready in cycle T+N+2.
- DUMP accepted at edge T with dump_ready held high: word k is valid in cycle T+2+2k; done in cycle T+2N+1; cmd_ready in cycle T+2N+2.
- dump_ready low holds DUMP_OUT indefinitely with outputs unchanged. dump_ready high outside DUMP_OUT has no effect.

## Test plan
- Reset, then FILL with cmd_data=0xA5A5_0001 -> 32 consecutive doRegWrite cycles with regToWrite 0..31; done pulses once 33 cycles after acceptance; a model register file holds 0xA5A5_0001 everywhere.
- Preload file[i]=i*0x1111, then DUMP with dump_ready=1 -> 32 words with dump_index 0..31 and dump_data=i*0x1111, one every 2 cycles; done 65 cycles after acceptance.
- DUMP with dump_ready toggling randomly -> dump_data and dump_index stable while stalled, no word lost or duplicated, order 0..31.
- Pulse cmd_valid (op=FILL, data=0xFFFF_FFFF) during an active DUMP -> ignored; no doRegWrite; dump completes unchanged; cmd_ready stays 0 until after done.
- Assert rst at the 10th FILL cycle -> doRegWrite=0 immediately; registers 0..8 written and 9..31 untouched; after release: IDLE, cmd_ready=1, all outputs at reset values.
- Back-to-back: FILL 0x0 then DUMP issued on the first cmd_ready cycle -> all 32 dumped words equal 0x0.
